cordic_rotate: RTL and testbench

CORDIC_ROTATE -- requirements
Module: cordic_rotate

---
 rtl/cordic_rotate.sv | 164 ++++++++++++++++
 tb/tb_cordic_rotate.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cordic_rotate.sv
// Rotation-mode CORDIC polar-to-cartesian converter: one sample per clock,
// fixed latency T_IR_NUM+2, angle encoded as alpha/(2*pi) * 2^DW_NOR.
module cordic_rotate #(
    parameter int DW       = 16,
    parameter int T_IR_NUM = 15,
    parameter int DW_DOT   = 4,
    parameter int DW_NOR   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_vsync,
    input  logic                 din_hsync,
    input  logic [DW-1:0]        din_radians,
    input  logic [DW_NOR-1:0]    din_angle,
    output logic                 dout_vsync,
    output logic                 dout_hsync,
    output logic signed [DW-1:0] dout_x,
    output logic signed [DW-1:0] dout_y
);
    localparam int IW = DW + DW_DOT + 1;
    localparam int ZW = DW_NOR + 1;
    localparam int PW = DW + 17;

    localparam logic [PW-1:0]        K_C      = PW'(39797);
    localparam logic [PW-1:0]        X0_RND_C = PW'(1) << (15 - DW_DOT);
    localparam logic signed [IW:0]   RND_C    = (IW+1)'(1) << (DW_DOT - 1);
    localparam logic signed [IW:0]   SAT_HI_C = (IW+1)'((1 << (DW - 1)) - 1);
    localparam logic signed [IW:0]   SAT_LO_C = -SAT_HI_C;

    // atan(2^-i) in angle units of 2^DW_NOR per full turn
    function automatic logic signed [ZW-1:0] atan_f(input int i);
        case (i)
            0:       atan_f = ZW'(131072);
            1:       atan_f = ZW'(77376);
            2:       atan_f = ZW'(40884);
            3:       atan_f = ZW'(20753);
            4:       atan_f = ZW'(10417);
            5:       atan_f = ZW'(5213);
            6:       atan_f = ZW'(2607);
            7:       atan_f = ZW'(1304);
            8:       atan_f = ZW'(652);
            9:       atan_f = ZW'(326);
            10:      atan_f = ZW'(163);
            11:      atan_f = ZW'(81);
            12:      atan_f = ZW'(41);
            13:      atan_f = ZW'(20);
            14:      atan_f = ZW'(10);
            15:      atan_f = ZW'(5);
            16:      atan_f = ZW'(3);
            17:      atan_f = ZW'(1);
            default: atan_f = '0;
        endcase
    endfunction

    function automatic logic signed [DW-1:0] sat_f(input logic signed [IW:0] v);
        if (v > SAT_HI_C) begin
            sat_f = SAT_HI_C[DW-1:0];
        end else if (v < SAT_LO_C) begin
            sat_f = SAT_LO_C[DW-1:0];
        end else begin
            sat_f = v[DW-1:0];
        end
    endfunction

    // index 0 holds the stage-0 registers, index i+1 the result of rotation step i
    logic signed [IW-1:0] x_q  [0:T_IR_NUM];
    logic signed [IW-1:0] x_d  [0:T_IR_NUM];
    logic signed [IW-1:0] y_q  [0:T_IR_NUM];
    logic signed [IW-1:0] y_d  [0:T_IR_NUM];
    logic signed [ZW-1:0] z_q  [0:T_IR_NUM];
    logic signed [ZW-1:0] z_d  [0:T_IR_NUM];
    logic [1:0]           q_q  [0:T_IR_NUM];
    logic [1:0]           q_d  [0:T_IR_NUM];
    logic                 vs_q [0:T_IR_NUM];
    logic                 vs_d [0:T_IR_NUM];
    logic                 hs_q [0:T_IR_NUM];
    logic                 hs_d [0:T_IR_NUM];

    logic [PW-1:0]        x0_prod_s;
    logic signed [IW:0]   xr_s;
    logic signed [IW:0]   yr_s;
    logic signed [DW-1:0] xs_s;
    logic signed [DW-1:0] ys_s;
    logic signed [DW-1:0] ox_s;
    logic signed [DW-1:0] oy_s;

    // stage 0 (gain pre-compensation, quadrant split) and the rotation steps
    always_comb begin
        x0_prod_s = PW'(din_radians) * K_C + X0_RND_C;
        x_d[0]    = IW'(x0_prod_s >> (16 - DW_DOT));
        y_d[0]    = '0;
        z_d[0]    = {3'b000, din_angle[DW_NOR-3:0]};
        q_d[0]    = din_angle[DW_NOR-1:DW_NOR-2];
        vs_d[0]   = din_vsync;
        hs_d[0]   = din_hsync;
        for (int i = 0; i < T_IR_NUM; i++) begin
            if (!z_q[i][ZW-1]) begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
                z_d[i+1] = z_q[i] - atan_f(i);
            end else begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
                z_d[i+1] = z_q[i] + atan_f(i);
            end
            q_d[i+1]  = q_q[i];
            vs_d[i+1] = vs_q[i];
            hs_d[i+1] = hs_q[i];
        end
    end

    // final stage: round away the fraction bits, saturate, then map back to the quadrant
    always_comb begin
        xr_s = ($signed({x_q[T_IR_NUM][IW-1], x_q[T_IR_NUM]}) + RND_C) >>> DW_DOT;
        yr_s = ($signed({y_q[T_IR_NUM][IW-1], y_q[T_IR_NUM]}) + RND_C) >>> DW_DOT;
        xs_s = sat_f(xr_s);
        ys_s = sat_f(yr_s);
        case (q_q[T_IR_NUM])
            2'd0:    begin ox_s = xs_s;  oy_s = ys_s;  end
            2'd1:    begin ox_s = -ys_s; oy_s = xs_s;  end
            2'd2:    begin ox_s = -xs_s; oy_s = -ys_s; end
            2'd3:    begin ox_s = ys_s;  oy_s = -xs_s; end
            default: begin ox_s = '0;    oy_s = '0;    end
        endcase
    end

    // pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= T_IR_NUM; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                z_q[i]  <= '0;
                q_q[i]  <= 2'b00;
                vs_q[i] <= 1'b0;
                hs_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i <= T_IR_NUM; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                z_q[i]  <= z_d[i];
                q_q[i]  <= q_d[i];
                vs_q[i] <= vs_d[i];
                hs_q[i] <= hs_d[i];
            end
        end
    end

    // output registers; data is forced to zero outside valid samples
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vsync <= 1'b0;
            dout_hsync <= 1'b0;
            dout_x     <= '0;
            dout_y     <= '0;
        end else begin
            dout_vsync <= vs_q[T_IR_NUM];
            dout_hsync <= hs_q[T_IR_NUM];
            dout_x     <= hs_q[T_IR_NUM] ? ox_s : '0;
            dout_y     <= hs_q[T_IR_NUM] ? oy_s : '0;
        end
    end
endmodule

// File: tb/tb_cordic_rotate.sv
// Scoreboard bench for cordic_rotate: expected results come from real-valued
// trigonometry on the issued (R, angle) pairs; sync timing from an input history.
module tb_cordic_rotate;
    localparam int    LAT  = 17;
    localparam int    HN   = 4096;
    localparam real   PI2  = 6.283185307179586;
    localparam real   TURN = 1048576.0;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               din_vsync = 1'b0;
    logic               din_hsync = 1'b0;
    logic [15:0]        din_radians = 16'd0;
    logic [19:0]        din_angle = 20'd0;
    logic               dout_vsync;
    logic               dout_hsync;
    logic signed [15:0] dout_x;
    logic signed [15:0] dout_y;

    cordic_rotate dut (
        .clk(clk), .rst(rst), .din_vsync(din_vsync), .din_hsync(din_hsync),
        .din_radians(din_radians), .din_angle(din_angle),
        .dout_vsync(dout_vsync), .dout_hsync(dout_hsync),
        .dout_x(dout_x), .dout_y(dout_y)
    );

    always #5 clk = ~clk;

    // mode 0: within +-1 of ideal, mode 1: polar loopback, mode 2: exact zero
    typedef struct {
        int r;
        int ang;
        int mode;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_rst_edge = 1;
    bit   vs_hist [0:HN-1];
    bit   hs_hist [0:HN-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else return -$rtoi(-v + 0.5);
    endfunction

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        else if (v < -32767) return -32767;
        else return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic drive(input bit r, input bit vs, input bit hs, input int rad,
                         input int ang, input int mode);
        exp_t it;
        int   e;
        @(negedge clk);
        rst         = r;
        din_vsync   = vs;
        din_hsync   = hs;
        din_radians = 16'(rad);
        din_angle   = 20'(ang);
        e = cyc + 1;
        vs_hist[e % HN] = vs;
        hs_hist[e % HN] = hs;
        if (r) begin
            last_rst_edge = e;
            sb_q.delete();
        end else if (hs) begin
            it.r = rad; it.ang = ang; it.mode = mode;
            sb_q.push_back(it);
        end
    endtask

    // monitor: compares every cycle, pops the scoreboard whenever a sample emerges
    initial begin
        int   src;
        bit   evs, ehs;
        exp_t it;
        real  a, rr, units, d;
        int   ex, ey;
        forever begin
            @(posedge clk);
            #1;
            src = cyc - (LAT - 1);
            if (src > last_rst_edge) begin
                evs = vs_hist[src % HN];
                ehs = hs_hist[src % HN];
            end else begin
                evs = 1'b0;
                ehs = 1'b0;
            end
            check("vsync", dout_vsync == evs, int'(dout_vsync), int'(evs));
            check("hsync", dout_hsync == ehs, int'(dout_hsync), int'(ehs));
            if (dout_hsync !== 1'b1) begin
                check("x_idle", dout_x == 16'sd0, int'(dout_x), 0);
                check("y_idle", dout_y == 16'sd0, int'(dout_y), 0);
            end else if (sb_q.size() == 0) begin
                check("unexpected_sample", 1'b0, 1, 0);
            end else begin
                it = sb_q.pop_front();
                a  = real'(it.ang) * PI2 / TURN;
                if (it.mode == 1) begin
                    rr = $sqrt(real'(dout_x) * real'(dout_x) + real'(dout_y) * real'(dout_y));
                    check("loop_radius", (rr - real'(it.r) <= 2.0) && (real'(it.r) - rr <= 2.0),
                          rnd(rr), it.r);
                    units = $atan2(real'(dout_y), real'(dout_x)) / PI2 * TURN;
                    d = units - real'(it.ang);
                    while (d > 524288.0) d = d - TURN;
                    while (d < -524288.0) d = d + TURN;
                    check("loop_angle", (d <= 60.0) && (d >= -60.0),
                          rnd(units < 0.0 ? units + TURN : units), it.ang);
                end else begin
                    ex = sat(rnd(real'(it.r) * $cos(a)));
                    ey = sat(rnd(real'(it.r) * $sin(a)));
                    if (it.mode == 2) begin
                        check("x_zero_len", int'(dout_x) == ex, int'(dout_x), ex);
                        check("y_zero_len", int'(dout_y) == ey, int'(dout_y), ey);
                    end else begin
                        check("x_value", iabs(int'(dout_x) - ex) <= 1, int'(dout_x), ex);
                        check("y_value", iabs(int'(dout_y) - ey) <= 1, int'(dout_y), ey);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        bit vs;
        int ang;
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);

        drive(1'b0, 1'b1, 1'b1, 1000, 32'h00000, 0);
        drive(1'b0, 1'b1, 1'b1, 1000, 32'h40000, 0);
        drive(1'b0, 1'b1, 1'b1, 1000, 32'h80000, 0);
        drive(1'b0, 1'b1, 1'b1, 1000, 32'hC0000, 0);
        drive(1'b0, 1'b1, 1'b1, 8192, 32'h20000, 0);
        drive(1'b0, 1'b1, 1'b1, 8192, 32'hE0000, 0);
        drive(1'b0, 1'b1, 1'b1, 0, int'($urandom_range(0, 1048575)), 2);
        drive(1'b0, 1'b1, 1'b1, 40000, 32'h00000, 0);
        drive(1'b0, 1'b1, 1'b1, 65535, 32'h40000, 0);
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);

        vs = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 31) == 0) vs = ~vs;
            ang = int'($urandom_range(0, 1048575));
            if (k % 37 == 0) ang = (k % 4) << 18;
            if (k == 200) begin
                drive(1'b1, vs, 1'b1, 1234, ang, 0);
            end else if ($urandom_range(0, 1) == 1) begin
                drive(1'b0, vs, $urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)), ang, 0);
            end else begin
                drive(1'b0, vs, $urandom_range(0, 3) != 0, int'($urandom_range(8192, 16383)), ang, 1);
            end
        end

        for (int k = 0; k < 30; k++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("sb_drained", sb_q.size() == 0, sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
